// File: rtl/mfcc_melbank_filter_if.sv
// Bundle of the spectrum input stream, melbank ROM port and filter-energy output stream.
// The slave modport is the filterbank engine's view; master is the surrounding system's view.
interface mfcc_melbank_filter_if #(
   parameter int PW    = 24,
   parameter int ACC_W = 40
);
   logic             in_valid;
   logic             in_ready;
   logic [PW-1:0]    in_data;
   logic             in_last;
   logic [8:0]       rom_addr;
   logic [7:0]       rom_data;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-9:0] out_data;
   logic [7:0]       out_idx;
   logic             out_last;
   logic             err;

   modport slave (
      input  in_valid, in_data, in_last, rom_data, out_ready,
      output in_ready, rom_addr, out_valid, out_data, out_idx, out_last, err
   );

   modport master (
      output in_valid, in_data, in_last, rom_data, out_ready,
      input  in_ready, rom_addr, out_valid, out_data, out_idx, out_last, err
   );
endinterface

// File: rtl/mfcc_melbank_filter.sv
// Mel filterbank engine: per-bin power is split by a triangular weight into two adjacent filters.
// Optional build macro MELBANK_SAT_EN makes accumulator additions saturate instead of wrapping.
module mfcc_melbank_filter #(
   parameter int PW    = 24,
   parameter int ACC_W = 40,
   parameter int NBINS = 256,
   parameter int NFILT = 26
) (
   input  logic                  clk,
   input  logic                  rst,
   mfcc_melbank_filter_if.slave  bus
);
   localparam int PRW = PW + 9;
   localparam int OW  = ACC_W - 8;
`ifdef MELBANK_SAT_EN
   localparam int SW  = ((ACC_W > PRW) ? ACC_W : PRW) + 1;
`endif

   typedef enum logic [2:0] {S_IDLE, S_IDX, S_WGT, S_ACC, S_EMIT, S_FLUSH} state_t;

   state_t           state_q, state_d;
   logic [PW-1:0]    p_q, p_d;
   logic             last_q, last_d;
   logic [7:0]       f_q, f_d;
   logic [PRW-1:0]   ph_q, ph_d;
   logic [PRW-1:0]   pl_q, pl_d;
   logic [7:0]       cur_f_q, cur_f_d;
   logic [7:0]       bc_q, bc_d;
   logic [ACC_W-1:0] acc_lo_q, acc_lo_d;
   logic [ACC_W-1:0] acc_hi_q, acc_hi_d;
   logic [8:0]       rom_addr_q, rom_addr_d;
   logic             out_valid_q, out_valid_d;
   logic [OW-1:0]    out_data_q, out_data_d;
   logic [7:0]       out_idx_q, out_idx_d;
   logic             out_last_q, out_last_d;
   logic             err_q, err_d;
   logic             emit_load;
   logic             flush_load;

   function automatic logic [ACC_W-1:0] acc_add(input logic [ACC_W-1:0] a,
                                                input logic [PRW-1:0]   b);
`ifdef MELBANK_SAT_EN
      logic [SW-1:0] s;
      s = SW'(a) + SW'(b);
      return (s > SW'({ACC_W{1'b1}})) ? {ACC_W{1'b1}} : s[ACC_W-1:0];
`else
      return a + ACC_W'(b);
`endif
   endfunction

   assign bus.in_ready  = (state_q == S_IDLE) && !rst;
   assign bus.rom_addr  = rom_addr_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_idx   = out_idx_q;
   assign bus.out_last  = out_last_q;
   assign bus.err       = err_q;

   always_comb begin
      state_d     = state_q;
      p_d         = p_q;
      last_d      = last_q;
      f_d         = f_q;
      ph_d        = ph_q;
      pl_d        = pl_q;
      cur_f_d     = cur_f_q;
      bc_d        = bc_q;
      acc_lo_d    = acc_lo_q;
      acc_hi_d    = acc_hi_q;
      rom_addr_d  = rom_addr_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_idx_d   = out_idx_q;
      out_last_d  = out_last_q;
      err_d       = err_q;
      emit_load   = 1'b0;
      flush_load  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.in_valid && !rst) begin
               p_d        = bus.in_data;
               last_d     = bus.in_last || (bc_q == 8'(NBINS - 1));
               if ((bc_q == 8'(NBINS - 1)) && !bus.in_last) err_d = 1'b1;
               rom_addr_d = {1'b1, bc_q};
               state_d    = S_IDX;
            end
         end
         S_IDX: begin
            f_d        = bus.rom_data;
            rom_addr_d = {1'b0, bc_q};
            state_d    = S_WGT;
         end
         S_WGT: begin
            ph_d    = PRW'(p_q) * PRW'(bus.rom_data);
            pl_d    = PRW'(p_q) * PRW'(9'd256 - {1'b0, bus.rom_data});
            state_d = S_ACC;
         end
         S_ACC: begin
            if (f_q == cur_f_q) begin
               if (f_q < 8'(NFILT)) acc_hi_d = acc_add(acc_hi_q, ph_q);
               if (f_q != 8'd0)     acc_lo_d = acc_add(acc_lo_q, pl_q);
            end else if ({1'b0, f_q} == ({1'b0, cur_f_q} + 9'd1)) begin
               // Moving to the next filter: the low filter is now complete.
               if (cur_f_q != 8'd0) begin
                  emit_load   = 1'b1;
                  out_valid_d = 1'b1;
                  out_data_d  = acc_lo_q[ACC_W-1:8];
                  out_idx_d   = cur_f_q - 8'd1;
                  out_last_d  = 1'b0;
               end
               acc_lo_d = acc_add(acc_hi_q, pl_q);
               acc_hi_d = (f_q < 8'(NFILT)) ? acc_add('0, ph_q) : '0;
               cur_f_d  = f_q;
            end else begin
               err_d = 1'b1;
            end
            bc_d = bc_q + 8'd1;
            if (emit_load) begin
               state_d = S_EMIT;
            end else if (last_q) begin
               state_d    = S_FLUSH;
               flush_load = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_EMIT: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               if (last_q) begin
                  state_d    = S_FLUSH;
                  flush_load = 1'b1;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_FLUSH: begin
            if (!out_valid_q || bus.out_ready) begin
               out_valid_d = 1'b0;
               cur_f_d     = 8'd0;
               bc_d        = 8'd0;
               acc_lo_d    = '0;
               acc_hi_d    = '0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Final filter of the frame is taken from the post-update accumulator state.
      if (flush_load) begin
         if (cur_f_d != 8'd0) begin
            out_valid_d = 1'b1;
            out_data_d  = acc_lo_d[ACC_W-1:8];
            out_idx_d   = cur_f_d - 8'd1;
            out_last_d  = 1'b1;
         end else begin
            err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         p_q         <= '0;
         last_q      <= 1'b0;
         f_q         <= '0;
         ph_q        <= '0;
         pl_q        <= '0;
         cur_f_q     <= '0;
         bc_q        <= '0;
         acc_lo_q    <= '0;
         acc_hi_q    <= '0;
         rom_addr_q  <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_idx_q   <= '0;
         out_last_q  <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         p_q         <= p_d;
         last_q      <= last_d;
         f_q         <= f_d;
         ph_q        <= ph_d;
         pl_q        <= pl_d;
         cur_f_q     <= cur_f_d;
         bc_q        <= bc_d;
         acc_lo_q    <= acc_lo_d;
         acc_hi_q    <= acc_hi_d;
         rom_addr_q  <= rom_addr_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_idx_q   <= out_idx_d;
         out_last_q  <= out_last_d;
         err_q       <= err_d;
      end
   end
endmodule

// File: tb/tb_mfcc_melbank_filter.sv
// Scoreboard bench for mfcc_melbank_filter: directed frames plus randomized frames against
// a filter-energy array model; honours MELBANK_SAT_EN when the build defines it.
module tb_mfcc_melbank_filter;
   localparam int PW    = 24;
   localparam int ACC_W = 20;
   localparam int NBINS = 8;
   localparam int NFILT = 2;
   localparam int OW    = ACC_W - 8;
`ifdef MELBANK_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   typedef struct packed {
      logic [OW-1:0] data;
      logic [7:0]    idx;
      logic          last;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mfcc_melbank_filter_if #(.PW(PW), .ACC_W(ACC_W)) bus();

   mfcc_melbank_filter #(.PW(PW), .ACC_W(ACC_W), .NBINS(NBINS), .NFILT(NFILT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [7:0]    rom_f [256];
   logic [7:0]    rom_w [256];
   logic [PW-1:0] fp [NBINS];
   logic [7:0]    tf [NBINS];
   logic [7:0]    tw [NBINS];
   int            last_at;
   exp_t          sb_q [$];
   bit            err_exp = 1'b0;
   int            ready_mode = 0;
   int            n_cmp = 0;
   int            n_bad = 0;

   always_comb bus.rom_data = bus.rom_addr[8] ? rom_f[bus.rom_addr[7:0]] : rom_w[bus.rom_addr[7:0]];

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endfunction

   function automatic longint macc(input longint a, input longint b);
      longint top = (longint'(1) << ACC_W) - 1;
      longint s   = a + b;
      if (SAT) return (s > top) ? top : s;
      return s & top;
   endfunction

   // Reference: one energy per filter; a bin feeds filter f with p*w and filter f-1 with p*(256-w).
   task automatic model_frame();
      longint e [256];
      int     cur = 0;
      int     nb;
      exp_t   x;
      foreach (e[k]) e[k] = 0;
      nb = (last_at >= 0) ? last_at + 1 : NBINS;
      for (int i = 0; i < nb; i++) begin
         int     f  = int'(tf[i]);
         longint ph = longint'(fp[i]) * longint'(tw[i]);
         longint pl = longint'(fp[i]) * (256 - longint'(tw[i]));
         if (i == NBINS - 1 && last_at != i) err_exp = 1'b1;
         if (f == cur || f == cur + 1) begin
            if (f == cur + 1 && cur >= 1) begin
               x.data = OW'(e[cur-1] >> 8);
               x.idx  = 8'(cur - 1);
               x.last = 1'b0;
               sb_q.push_back(x);
            end
            if (f < NFILT) e[f] = macc(e[f], ph);
            if (f >= 1)    e[f-1] = macc(e[f-1], pl);
            cur = f;
         end else begin
            err_exp = 1'b1;
         end
      end
      if (cur >= 1) begin
         x.data = OW'(e[cur-1] >> 8);
         x.idx  = 8'(cur - 1);
         x.last = 1'b1;
         sb_q.push_back(x);
      end else begin
         err_exp = 1'b1;
      end
   endtask

   task automatic send_bin(input logic [PW-1:0] p, input logic l);
      int n = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = p;
      bus.in_last  = l;
      @(negedge clk);
      while (!bus.in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("bin_accept", bus.in_ready, 1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (!(sb_q.size() == 0 && bus.in_ready) && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("frame_drain", (sb_q.size() == 0 && bus.in_ready), 1);
      @(posedge clk);
      #1;
   endtask

   task automatic run_frame();
      int nb;
      for (int k = 0; k < NBINS; k++) begin
         rom_f[k] = tf[k];
         rom_w[k] = tw[k];
      end
      model_frame();
      nb = (last_at >= 0) ? last_at + 1 : NBINS;
      for (int i = 0; i < nb; i++) send_bin(fp[i], (i == last_at));
      wait_idle();
      chk("err_flag", bus.err, err_exp);
   endtask

   task automatic base_frame();
      for (int i = 0; i < NBINS; i++) begin
         tf[i] = 8'(i / 2);
         tw[i] = (i < 4) ? 8'd128 : 8'd64;
         fp[i] = 24'd256;
      end
      tf[5] = 8'd2; tf[6] = 8'd2; tf[7] = 8'd2;
      last_at = NBINS - 1;
   endtask

   task automatic rand_frame();
      int f = 0;
      for (int i = 0; i < NBINS; i++) begin
         if ($urandom_range(0, 15) == 0) f = $urandom_range(0, 4);
         else if ($urandom_range(0, 2) == 0) f = f + 1;
         if (f > 4) f = 4;
         tf[i] = 8'(f);
         if ($urandom_range(0, 7) == 0) tw[i] = ($urandom_range(0, 1) == 1) ? 8'd255 : 8'd0;
         else tw[i] = 8'($urandom_range(0, 255));
         fp[i] = ($urandom_range(0, 1) == 1) ? 24'($urandom_range(0, 4095)) : 24'($urandom);
      end
      last_at = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, NBINS - 1));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      err_exp = 1'b0;
   endtask

   // out_ready driver: 0 = always ready, 1 = random, otherwise held low
   initial begin
      bus.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = 1'($urandom_range(0, 1));
            default: bus.out_ready = 1'b0;
         endcase
      end
   end

   // Monitor: every presented output must match the scoreboard head until it is accepted.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && bus.out_valid) begin
            chk("in_ready_during_out", bus.in_ready, 0);
            if (sb_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_out: got idx %0d data 0x%0h, expected no output",
                        bus.out_idx, bus.out_data);
            end else begin
               chk("out_data", bus.out_data, sb_q[0].data);
               chk("out_idx", bus.out_idx, sb_q[0].idx);
               chk("out_last", bus.out_last, sb_q[0].last);
               if (bus.out_ready) begin
                  $display("out idx=%0d data=0x%0h last=%0b", bus.out_idx, bus.out_data, bus.out_last);
                  void'(sb_q.pop_front());
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.in_last  = 1'b0;
      foreach (rom_f[k]) begin
         rom_f[k] = 8'd0;
         rom_w[k] = 8'd0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_data", bus.out_data, 0);
      chk("rst_out_idx", bus.out_idx, 0);
      chk("rst_out_last", bus.out_last, 0);
      chk("rst_rom_addr", bus.rom_addr, 0);
      chk("rst_err", bus.err, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", bus.in_ready, 1);
      @(posedge clk);
      #1;

      // Basic frame: expected (idx0, 512) then (idx1, 1024, last)
      base_frame();
      run_frame();

      // Same frame with the first output stalled for 10 cycles
      ready_mode = 2;
      base_frame();
      fork
         run_frame();
         begin
            int n = 0;
            while (!bus.out_valid && n < 200) begin
               @(negedge clk);
               n++;
            end
            chk("stall_out_valid", bus.out_valid, 1);
            repeat (10) begin
               @(negedge clk);
               chk("stall_in_ready", bus.in_ready, 0);
            end
            ready_mode = 0;
         end
      join

      // Illegal filter jump 0 -> 2 at bin 2
      base_frame();
      tf[2] = 8'd2; tf[3] = 8'd1; tf[4] = 8'd1;
      run_frame();

      // Reset while the third bin is in the weight stage
      base_frame();
      for (int k = 0; k < NBINS; k++) begin
         rom_f[k] = tf[k];
         rom_w[k] = tw[k];
      end
      send_bin(fp[0], 1'b0);
      send_bin(fp[1], 1'b0);
      send_bin(fp[2], 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_in_ready", bus.in_ready, 0);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("midrst_out_valid", bus.out_valid, 0);
      chk("midrst_rom_addr", bus.rom_addr, 0);
      chk("midrst_err", bus.err, 0);
      chk("midrst_out_data", bus.out_data, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      err_exp = 1'b0;
      base_frame();
      run_frame();

      // Frame without in_last: forced end after the final bin
      base_frame();
      last_at = -1;
      run_frame();

      // Full-scale power and weight: saturation or wrap depending on build
      base_frame();
      for (int i = 0; i < NBINS; i++) begin
         fp[i] = 24'hFFFFFF;
         tw[i] = 8'd255;
      end
      run_frame();

      ready_mode = 1;
      for (int r = 0; r < 32; r++) begin
         if (r % 8 == 0) do_reset();
         rand_frame();
         run_frame();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/mfcc_melbank_filter.md
# mfcc_melbank_filter

Mel filterbank engine of the MFCC front end: consumes the per-bin power spectrum stream from the FFT magnitude stage, reads per-bin filter index and triangular weight from the melbank coefficient ROM (9-bit address, 8-bit data, combinational read), and accumulates weighted power into overlapping triangular filters. It emits one energy word per completed filter to the log/DCT stage. This block is the reading master of the melbank ROM interface.

## Interface
Parameters:
- PW, 24, input power word width (unsigned)
- ACC_W, 40, accumulator width; out_data is ACC_W-8 bits
- NBINS, 256, bins per frame (≤256)
- NFILT, 26, number of mel filters (≤255)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  power bin valid
- in_ready  out  1  bin accepted when in_valid & in_ready
- in_data  in  PW  bin power
- in_last  in  1  final bin of frame
- rom_addr  out  9  ROM address; {1,bin} = filter index f, {0,bin} = weight w
- rom_data  in  8  ROM read data, valid same cycle as rom_addr
- out_valid  out  1  filter energy valid
- out_ready  in  1  downstream accept
- out_data  out  ACC_W-8  filter energy = acc>>8
- out_idx  out  8  filter number
- out_last  out  1  final filter of frame
- err  out  1  sticky table/framing error

## Operation
- State: cur_f (8b), bin counter bc, acc_lo (filter cur_f-1), acc_hi (filter cur_f), all cleared at frame start.
- IDLE: in_ready=1. On accept: latch p, last=in_last|(bc==NBINS-1); rom_addr={1,bc} -> IDX.
- IDX: f<=rom_data; rom_addr={0,bc} -> WGT.
- WGT: w<=rom_data; ph<=p*w, pl<=p*(256-w) (PW+9 bits) -> ACC.
- ACC:
  - f==cur_f: acc_hi+=ph (if f<NFILT), acc_lo+=pl (if f≥1).
  - f==cur_f+1: if cur_f≥1 load output {acc_lo, cur_f-1} -> EMIT; acc_lo<=acc_hi+pl; acc_hi<=(f<NFILT)?ph:0; cur_f<=f.
  - otherwise: err<=1, bin ignored.
  - then: EMIT if loaded, else FLUSH if last, else IDLE; bc++.
- EMIT: out_valid=1, hold until out_ready; then FLUSH if last else IDLE.
- FLUSH: if cur_f≥1 and not yet flushed, present {acc_lo, cur_f-1} with out_last=1, wait out_ready; then clear frame state -> IDLE. cur_f==0: no output, err<=1.
- in_last before bc==NBINS-1: frame ends normally. bc==NBINS-1 without in_last: frame ends, err<=1.
- Accumulation wraps modulo 2^ACC_W (see Configuration).

## Timing
- Reset: in_ready=0 during rst, 1 first cycle after; out_valid=0, out_data=0, out_idx=0, out_last=0, rom_addr=0, err=0, state IDLE, accumulators 0.
- Bin accepted cycle 0; IDX 1, WGT 2, ACC 3; in_ready=1 at cycle 4 without emit. Max throughput one bin per 4 cycles.
- Emit: out_valid first at cycle 4; in_ready stays 0 until the cycle after out_valid&out_ready.
- out_data/out_idx/out_last stable while out_valid & !out_ready.
- rom_addr changes only on state transitions; data sampled in same cycle.
- Reset mid-frame: partial frame discarded, no output.

## Configuration
- MELBANK_SAT_EN defined: acc_lo/acc_hi additions saturate at 2^ACC_W-1.
- Undefined: additions wrap modulo 2^ACC_W.

## Test plan
- NBINS=8, NFILT=2; ROM f={0,0,1,1,2,2,2,2}, w={128,128,128,128,64,64,64,64}; all p=256, in_last on bin 7 -> out (idx0, data 512, last 0), then (idx1, data 1024, last 1); err=0.
- Same, out_ready low 10 cycles on first output -> data/idx held, in_ready=0 throughout, values unchanged.
- f jumps 0->2 at bin 2 -> err=1 sticky, bin 2 ignored, rest of frame continues.
- PW=24, ACC_W=20, p=0xFFFFFF, w=255 every bin -> with MELBANK_SAT_EN out_data=0xFFF; without, wrapped value.
- rst asserted in WGT mid-frame -> next cycle all outputs reset values, next frame identical to first test.
- No in_last for 8 bins -> flush after bin 7, err=1, outputs as first test.
